// File: rtl/memshare_rr_arbiter.sv
// Round-robin grant arbiter for requesters that share one memory group.
// Requests are posted into a pending register. Each cycle with the memory
// port available, up to COL_PARALLELISM pending requesters are granted,
// scanning upward from a rotating pointer. All outputs are registered.
module memshare_rr_arbiter #(
    parameter int SHARED_GROUP_SIZE = 4,
    parameter int COL_PARALLELISM   = 1
) (
    input  logic                                   sys_clk,
    input  logic                                   rst,
    input  logic [SHARED_GROUP_SIZE-1:0]           rqst_in,
    input  logic                                   grant_en,
    output logic [SHARED_GROUP_SIZE-1:0]           grant_out,
    output logic                                   grant_vld,
    output logic [$clog2(SHARED_GROUP_SIZE+1)-1:0] grant_cnt,
    output logic [SHARED_GROUP_SIZE-1:0]           pending_out,
    output logic                                   round_done
);

    localparam int N     = SHARED_GROUP_SIZE;
    localparam int P     = COL_PARALLELISM;
    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    logic [N-1:0]     pending;
    logic [N-1:0]     pending_next;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [N-1:0]     sel;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             round_done_next;
    int               sel_num;
    int               scan_sum;

    // Walk the requesters in rotating order from ptr and pick the first P that are pending.
    always_comb begin
        sel      = '0;
        sel_num  = 0;
        last_idx = ptr;
        scan_sum = 0;
        scan_idx = '0;
        if (grant_en && (pending != '0)) begin
            for (int k = 0; k < N; k++) begin
                scan_sum = int'(ptr) + k;
                if (scan_sum >= N) begin
                    scan_sum = scan_sum - N;
                end
                scan_idx = PTR_W'(scan_sum);
                if (pending[scan_idx] && (sel_num < P)) begin
                    sel[scan_idx] = 1'b1;
                    sel_num       = sel_num + 1;
                    last_idx      = scan_idx;
                end
            end
        end
    end

    // Retire granted bits, absorb new requests, and move ptr just past the last grant.
    always_comb begin
        pending_next    = (pending & ~sel) | rqst_in;
        ptr_next        = ptr;
        round_done_next = 1'b0;
        if (sel != '0) begin
            if (last_idx == PTR_W'(N - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = last_idx + PTR_W'(1);
            end
            round_done_next = (pending != '0) && (pending_next == '0);
        end
    end

    // State and registered grant outputs; reset clears everything at once.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            ptr        <= '0;
            grant_out  <= '0;
            grant_vld  <= 1'b0;
            grant_cnt  <= '0;
            round_done <= 1'b0;
        end else begin
            pending    <= pending_next;
            ptr        <= ptr_next;
            grant_out  <= sel;
            grant_vld  <= (sel != '0);
            grant_cnt  <= CNT_W'(sel_num);
            round_done <= round_done_next;
        end
    end

    assign pending_out = pending;

endmodule
